// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector with a run-time loadable pattern and don't-care mask,
// selectable overlapping detection and a saturating match counter.
module mealy_seq_detector #(
    parameter int unsigned PAT_W   = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned OVERLAP = 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [PAT_W-1:0] mask_i,
    input  logic             valid_i,
    input  logic             in_i,
    input  logic             count_clr_i,
    output logic             match_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);

    localparam int unsigned FillW = $clog2(PAT_W);
    // Fill value at which the next valid bit completes the first full window.
    localparam logic [FillW-1:0] FillArm = FillW'(PAT_W - 2);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StArmed = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [FillW-1:0]   fill_q, fill_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sat_q, sat_d;

    logic [PAT_W-1:0]   win;
    logic               hit;

    assign win     = {hist_q, in_i};
    assign hit     = (((win ^ pat_q) & mask_q) == '0);
    assign match_o = en_i & ~load_i & valid_i & (state_q == StArmed) & hit;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        mask_d  = mask_q;

        if (load_i) begin
            pat_d  = pattern_i;
            mask_d = mask_i;
        end

        if (!en_i) begin
            state_d = StIdle;
            hist_d  = '0;
            fill_d  = '0;
        end else if (load_i) begin
            state_d = StFill;
            hist_d  = '0;
            fill_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StFill;
                    hist_d  = '0;
                    fill_d  = '0;
                end
                StFill: begin
                    if (valid_i) begin
                        hist_d = win[PAT_W-2:0];
                        fill_d = fill_q + FillW'(1);
                        if (fill_q == FillArm) begin
                            state_d = StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (valid_i) begin
                        if (match_o && (OVERLAP == 0)) begin
                            // Non-overlapping: the matching bit does not seed the next window.
                            state_d = StFill;
                            hist_d  = '0;
                            fill_d  = '0;
                        end else begin
                            hist_d = win[PAT_W-2:0];
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (count_clr_i) begin
            count_d = '0;
        end else if (match_o && !sat_q) begin
            count_d = count_q + CNT_W'(1);
        end
        sat_d = &count_d;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            mask_q  <= '1;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign state_o = state_q;
    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule
